// File: rtl/round_robin_arbiter_4_pkg.sv
// Shared types, constants and the rotate-priority pick used by the
// four-way round-robin arbiter.
package round_robin_arbiter_4_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Returns the first set candidate bit scanning ptr, ptr+1, ... mod 4.
  // The scan runs from the farthest offset down so the nearest one wins.
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                         input logic [1:0]         ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (cand[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/round_robin_arbiter_4_decoder.sv
// 2-to-4 enable decoder; turns the registered owner index into the
// one-hot grant vector.
module decoder_2_to_4 (
  input  logic EN,
  input  logic A1,
  input  logic A0,
  output logic D3,
  output logic D2,
  output logic D1,
  output logic D0
);

  assign D0 = EN & ~A1 & ~A0;
  assign D1 = EN & ~A1 &  A0;
  assign D2 = EN &  A1 & ~A0;
  assign D3 = EN &  A1 &  A0;

endmodule

// File: rtl/round_robin_arbiter_4.sv
// Four-requester round-robin arbiter with a per-tenure hold limit; a
// requester cut off by the limit is masked until it drops its request.
module round_robin_arbiter_4
  import round_robin_arbiter_4_pkg::*;
#(
  parameter int HOLD_MAX = 8,  // >= 1
  parameter int CNT_W    = 4   // 2**CNT_W > HOLD_MAX
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] REQ,
  output logic [NUM_REQ-1:0] GNT,
  output logic               VALID,
  output logic [1:0]         OWNER,
  output logic               TIMEOUT,
  output arb_state_t         state_dbg
);

  arb_state_t         state;
  logic [1:0]         owner;
  logic [1:0]         ptr;
  logic [NUM_REQ-1:0] mask;
  logic [CNT_W-1:0]   hold_cnt;
  logic               timeout;

  logic [NUM_REQ-1:0] cand;
  logic [1:0]         pick;
  logic               at_limit;

  assign cand     = REQ & ~mask;
  assign pick     = rr_pick(cand, ptr);
  assign at_limit = (hold_cnt == CNT_W'(HOLD_MAX - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      owner    <= 2'd0;
      ptr      <= 2'd0;
      mask     <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      // A requester that lets go of REQ earns back its eligibility.
      mask <= mask & REQ;
      case (state)
        ST_IDLE: begin
          timeout <= 1'b0;
          if (|cand) begin
            owner    <= pick;
            ptr      <= pick + 2'd1;
            hold_cnt <= '0;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (!REQ[owner]) begin
            state   <= ST_IDLE;
            timeout <= 1'b0;
          end else if (at_limit) begin
            state       <= ST_IDLE;
            timeout     <= 1'b1;
            mask[owner] <= 1'b1;
          end
        end
      endcase
    end
  end

  assign VALID     = (state == ST_BUSY);
  assign OWNER     = owner;
  assign TIMEOUT   = timeout;
  assign state_dbg = state;

  decoder_2_to_4 u_dec (
    .EN (VALID),
    .A1 (owner[1]),
    .A0 (owner[0]),
    .D3 (GNT[3]),
    .D2 (GNT[2]),
    .D1 (GNT[1]),
    .D0 (GNT[0])
  );

  a_gnt_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot0(GNT));
  a_valid_gnt:  assert property (@(posedge CLK) disable iff (RST) VALID == (|GNT));

endmodule

// File: tb/tb_round_robin_arbiter_4.sv
// Directed bench for round_robin_arbiter_4: the driver queues expected
// {GNT,VALID,OWNER,TIMEOUT} per cycle, a monitor pops and compares.
module tb_round_robin_arbiter_4;
  import round_robin_arbiter_4_pkg::*;

  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       valid;
  logic [1:0] owner;
  logic       timeout;
  arb_state_t state_dbg;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks;
  int           errors;

  round_robin_arbiter_4 #(.HOLD_MAX(8), .CNT_W(4)) dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ       (req),
    .GNT       (gnt),
    .VALID     (valid),
    .OWNER     (owner),
    .TIMEOUT   (timeout),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b1;
    req = 4'b0000;
  end

  // driver: inputs for the next rising edge plus outputs expected after it
  task automatic cyc(input string nm, input logic rst_v, input logic [3:0] req_v,
                     input logic [3:0] e_gnt, input logic [1:0] e_own, input logic e_to);
    logic [W-1:0] e;
    @(negedge clk);
    rst = rst_v;
    req = req_v;
    e = {e_gnt, (e_gnt != 4'b0000), e_own, e_to};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    string        nm;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {gnt, valid, owner, timeout};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got gnt=%b valid=%b owner=%0d timeout=%b, want gnt=%b valid=%b owner=%0d timeout=%b",
                 nm, act[7:4], act[3], act[2:1], act[0], e[7:4], e[3], e[2:1], e[0]);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;

    // reset with every request high
    for (int i = 0; i < 3; i++) cyc("reset", 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0);

    // single requester
    for (int i = 0; i < 3; i++) cyc("single_gnt", 1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0);
    cyc("single_drop", 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0);
    cyc("single_idle", 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0);

    // fairness: owners 0,1,2,3,0 with one idle cycle between tenures
    cyc("fair_rst", 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cyc("fair_o0a", 1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0);
    cyc("fair_o0b", 1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0);
    cyc("fair_gap0", 1'b0, 4'b1110, 4'b0000, 2'd0, 1'b0);
    cyc("fair_o1a", 1'b0, 4'b1111, 4'b0010, 2'd1, 1'b0);
    cyc("fair_o1b", 1'b0, 4'b1111, 4'b0010, 2'd1, 1'b0);
    cyc("fair_gap1", 1'b0, 4'b1101, 4'b0000, 2'd1, 1'b0);
    cyc("fair_o2a", 1'b0, 4'b1111, 4'b0100, 2'd2, 1'b0);
    cyc("fair_o2b", 1'b0, 4'b1111, 4'b0100, 2'd2, 1'b0);
    cyc("fair_gap2", 1'b0, 4'b1011, 4'b0000, 2'd2, 1'b0);
    cyc("fair_o3a", 1'b0, 4'b1111, 4'b1000, 2'd3, 1'b0);
    cyc("fair_o3b", 1'b0, 4'b1111, 4'b1000, 2'd3, 1'b0);
    cyc("fair_gap3", 1'b0, 4'b0111, 4'b0000, 2'd3, 1'b0);
    cyc("fair_o0c", 1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0);
    cyc("fair_o0d", 1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0);
    cyc("fair_gap4", 1'b0, 4'b1110, 4'b0000, 2'd0, 1'b0);
    cyc("fair_idle", 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // hold limit: 8 grant cycles, one TIMEOUT pulse, no regrant while held
    cyc("to_rst", 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    for (int i = 0; i < 8; i++) cyc("to_gnt", 1'b0, 4'b0001, 4'b0001, 2'd0, 1'b0);
    cyc("to_pulse", 1'b0, 4'b0001, 4'b0000, 2'd0, 1'b1);
    for (int i = 0; i < 11; i++) cyc("to_masked", 1'b0, 4'b0001, 4'b0000, 2'd0, 1'b0);
    cyc("to_other", 1'b0, 4'b0011, 4'b0010, 2'd1, 1'b0);
    cyc("to_release", 1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0);

    // reset mid-tenure, pointer back to 0
    cyc("mid_rst0", 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cyc("mid_o2a", 1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0);
    cyc("mid_o2b", 1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0);
    cyc("mid_rst", 1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0);
    cyc("mid_ptr0", 1'b0, 4'b1010, 4'b0010, 2'd1, 1'b0);
    cyc("mid_release", 1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0);

    // drop exactly on the limit cycle: normal release, regranted normally
    cyc("lim_rst", 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    for (int i = 0; i < 8; i++) cyc("lim_gnt", 1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0);
    cyc("lim_drop", 1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0);
    cyc("lim_regrant", 1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0);
    cyc("lim_release", 1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0);

    // drain: every queued expectation must have been consumed
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
